// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared definitions for the ADC configuration sequencer.
// Contents:
//   ADDR_W, DATA_W, IDX_W   command field and table index widths
//   RW_READ, RW_WRITE       cmd_rw encodings
//   state_e                 sequencer FSM states
//   rom_entry_t             one init-table entry {addr, data}
package spi_cfg_sequencer_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [3:0] {
        StIdle,
        StIdReq,
        StIdWait,
        StGap,
        StFetch,
        StWrReq,
        StWrWait,
        StXferReq,
        StXferWait,
        StDone,
        StErr
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rom_entry_t;

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Command/response channel between the sequencer and the SPI controller.
// Signals:
//   cmd_valid/cmd_ready     request handshake (sequencer -> controller)
//   cmd_rw, cmd_addr,       command payload, stable while cmd_valid is high
//   cmd_wdata
//   rsp_valid, rsp_rdata    one-cycle completion pulse and read data
// Modports: master = sequencer side, slave = controller side.
interface spi_cfg_sequencer_if;
    import spi_cfg_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/spi_cfg_rom.sv
// Fixed ADC init table with a registered read port.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_idx            table index
//   o_entry          registered {addr, data} of entry i_idx; zeros when out of range
module spi_cfg_rom
    import spi_cfg_sequencer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_idx,
    output rom_entry_t       o_entry
);

    rom_entry_t w_entry;
    rom_entry_t r_entry;

    always_comb begin
        w_entry = '0;
        case (i_idx)
            4'd0: begin w_entry.addr = 13'h000; w_entry.data = 8'h18; end
            4'd1: begin w_entry.addr = 13'h014; w_entry.data = 8'h01; end
            4'd2: begin w_entry.addr = 13'h00D; w_entry.data = 8'h00; end
            4'd3: begin w_entry.addr = 13'h016; w_entry.data = 8'h00; end
            default: w_entry = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_entry <= '0;
        end else begin
            r_entry <= w_entry;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// ADC configuration sequencer: on start, reads and checks the chip ID (with retries),
// writes the init table, then issues the transfer/update write. One command is
// outstanding at a time; each response is followed by an idle gap.
// Ports:
//   i_sys_clk, i_reset_n   clock, asynchronous active-low reset
//   i_start                one-cycle run request (ignored while busy)
//   o_busy, o_done,        status levels
//   o_error
//   o_id_seen              last chip ID value read
//   cmd_if                 command/response channel (master side)
module spi_cfg_sequencer
    import spi_cfg_sequencer_pkg::*;
#(
    parameter int unsigned       NUM_ENTRIES = 4,
    parameter int unsigned       GAP_CYCLES  = 16,
    parameter logic [ADDR_W-1:0] ID_ADDR     = 13'h001,
    parameter logic [DATA_W-1:0] ID_EXPECTED = 8'h93,
    parameter int unsigned       MAX_RETRY   = 3,
    parameter logic [ADDR_W-1:0] XFER_ADDR   = 13'h0FF,
    parameter logic [DATA_W-1:0] XFER_DATA   = 8'h01
) (
    input  logic              i_sys_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [DATA_W-1:0] o_id_seen,
    spi_cfg_sequencer_if.master cmd_if
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e             r_state, w_state;
    state_e             r_next, w_next;
    logic [RETRY_W-1:0] r_retry, w_retry;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [GAP_W-1:0]   r_gap, w_gap;
    logic [DATA_W-1:0]  r_id_seen, w_id_seen;
    logic               r_rw, w_rw;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic [DATA_W-1:0]  r_wdata, w_wdata;
    rom_entry_t         w_rom;

    spi_cfg_rom u_rom (
        .i_clk   (i_sys_clk),
        .i_rst_n (i_reset_n),
        .i_idx   (r_idx),
        .o_entry (w_rom)
    );

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StIdle;
            r_next    <= StIdle;
            r_retry   <= '0;
            r_idx     <= '0;
            r_gap     <= '0;
            r_id_seen <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state;
            r_next    <= w_next;
            r_retry   <= w_retry;
            r_idx     <= w_idx;
            r_gap     <= w_gap;
            r_id_seen <= w_id_seen;
            r_rw      <= w_rw;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_next    = r_next;
        w_retry   = r_retry;
        w_idx     = r_idx;
        w_gap     = r_gap;
        w_id_seen = r_id_seen;
        w_rw      = r_rw;
        w_addr    = r_addr;
        w_wdata   = r_wdata;

        case (r_state)
            StIdle, StDone, StErr: begin
                if (i_start) begin
                    w_state = StIdReq;
                    w_retry = '0;
                    w_idx   = '0;
                end
            end
            StIdReq: if (cmd_if.cmd_ready) w_state = StIdWait;
            StIdWait: begin
                if (cmd_if.rsp_valid) begin
                    w_id_seen = cmd_if.rsp_rdata;
                    if (cmd_if.rsp_rdata == ID_EXPECTED) begin
                        w_state = StGap;
                        w_next  = StFetch;
                    end else if (32'(r_retry) < MAX_RETRY) begin
                        w_retry = r_retry + RETRY_W'(1);
                        w_state = StGap;
                        w_next  = StIdReq;
                    end else begin
                        w_state = StErr;
                    end
                end
            end
            StGap: begin
                // Gap lasts max(GAP_CYCLES, 1) cycles.
                if (32'(r_gap) + 32'd1 >= GAP_CYCLES) begin
                    w_state = r_next;
                end else begin
                    w_gap = r_gap + GAP_W'(1);
                end
            end
            StFetch: w_state = StWrReq;
            StWrReq: if (cmd_if.cmd_ready) w_state = StWrWait;
            StWrWait: begin
                if (cmd_if.rsp_valid) begin
                    w_idx   = r_idx + 4'd1;
                    w_state = StGap;
                    w_next  = (32'(r_idx) == NUM_ENTRIES - 1) ? StXferReq : StFetch;
                end
            end
            StXferReq: if (cmd_if.cmd_ready) w_state = StXferWait;
            StXferWait: if (cmd_if.rsp_valid) w_state = StDone;
            default: w_state = StIdle;
        endcase

        // Payload is loaded on entry to a state and held there, so it stays stable
        // for as long as the request waits for cmd_ready.
        if (w_state != r_state) begin
            case (w_state)
                StIdReq: begin
                    w_rw    = RW_READ;
                    w_addr  = ID_ADDR;
                    w_wdata = '0;
                end
                StWrReq: begin
                    w_rw    = RW_WRITE;
                    w_addr  = w_rom.addr;
                    w_wdata = w_rom.data;
                end
                StXferReq: begin
                    w_rw    = RW_WRITE;
                    w_addr  = XFER_ADDR;
                    w_wdata = XFER_DATA;
                end
                StGap:   w_gap = '0;
                default: ;
            endcase
        end
    end

    assign cmd_if.cmd_valid = (r_state == StIdReq) || (r_state == StWrReq) ||
                              (r_state == StXferReq);
    assign cmd_if.cmd_rw    = r_rw;
    assign cmd_if.cmd_addr  = r_addr;
    assign cmd_if.cmd_wdata = r_wdata;

    assign o_busy    = !((r_state == StIdle) || (r_state == StDone) || (r_state == StErr));
    assign o_done    = (r_state == StDone);
    assign o_error   = (r_state == StErr);
    assign o_id_seen = r_id_seen;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer with a simple SPI-controller responder.
module tb_spi_cfg_sequencer;
    import spi_cfg_sequencer_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] id_seen;

    spi_cfg_sequencer_if u_if ();

    spi_cfg_sequencer u_dut (
        .i_sys_clk (clk),
        .i_reset_n (reset_n),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_error   (error),
        .o_id_seen (id_seen),
        .cmd_if    (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder log, written only by the responder process.
    logic [21:0] log_cmd  [0:255];
    int          log_rise [0:255];
    int          log_rsp  [0:255];
    int          n_cmd       = 0;
    int          n_rsp       = 0;
    int          id_reads    = 0;
    int          stall_total = 0;
    int          stall_bad   = 0;
    int          spur_done_n = 0;

    // Responder controls, written only by the main process.
    logic [7:0]  id_first    = 8'h93;
    logic [7:0]  id_rest     = 8'h93;
    int          id_base     = 0;
    logic [12:0] stall_addr  = 13'h1FFF;
    int          stall_limit = 0;
    int          spur_req_n  = 0;

    initial begin
        int         delay;
        int         pidx;
        int         rise;
        logic [7:0] prdata;
        logic       prev_v;
        logic       stall;
        delay  = 0;
        pidx   = 0;
        rise   = 0;
        prdata = 8'h00;
        prev_v = 1'b0;
        u_if.cmd_ready = 1'b0;
        u_if.rsp_valid = 1'b0;
        u_if.rsp_rdata = 8'h00;
        forever begin
            @(negedge clk);
            u_if.rsp_valid = 1'b0;
            u_if.rsp_rdata = 8'h00;
            if (!reset_n) begin
                delay          = 0;
                prev_v         = 1'b0;
                u_if.cmd_ready = 1'b0;
            end else begin
                if (delay > 0) begin
                    delay--;
                    if (delay == 0) begin
                        u_if.rsp_valid = 1'b1;
                        u_if.rsp_rdata = prdata;
                        log_rsp[pidx]  = cyc;
                        n_rsp++;
                    end
                end
                if (spur_done_n != spur_req_n) begin
                    spur_done_n    = spur_req_n;
                    u_if.rsp_valid = 1'b1;
                    u_if.rsp_rdata = 8'h00;
                end
                if (u_if.cmd_valid && !prev_v) rise = cyc;
                prev_v = u_if.cmd_valid;
                stall  = u_if.cmd_valid && !u_if.cmd_rw && (u_if.cmd_addr == stall_addr) &&
                         (stall_total < stall_limit);
                if (stall) begin
                    stall_total++;
                    if (u_if.cmd_addr != 13'h014 || u_if.cmd_wdata != 8'h01) stall_bad++;
                end
                u_if.cmd_ready = !stall;
                if (u_if.cmd_valid && u_if.cmd_ready) begin
                    log_cmd[n_cmd]  = {u_if.cmd_rw, u_if.cmd_addr, u_if.cmd_wdata};
                    log_rise[n_cmd] = rise;
                    pidx            = n_cmd;
                    n_cmd++;
                    delay  = 3;
                    prdata = 8'h00;
                    if (u_if.cmd_rw) begin
                        prdata = (id_reads == id_base) ? id_first : id_rest;
                        id_reads++;
                    end
                end
            end
        end
    end

    logic [21:0] exp_cmd [0:15];
    int          n_exp;
    int          base;
    int          rsp_base;

    function automatic logic [21:0] mk(input logic rw, input logic [12:0] a,
                                       input logic [7:0] d);
        return {rw, a, d};
    endfunction

    task automatic exp_clean(input int reads);
        n_exp = 0;
        for (int i = 0; i < reads; i++) begin
            exp_cmd[n_exp] = mk(1'b1, 13'h001, 8'h00);
            n_exp++;
        end
        exp_cmd[n_exp]     = mk(1'b0, 13'h000, 8'h18);
        exp_cmd[n_exp + 1] = mk(1'b0, 13'h014, 8'h01);
        exp_cmd[n_exp + 2] = mk(1'b0, 13'h00D, 8'h00);
        exp_cmd[n_exp + 3] = mk(1'b0, 13'h016, 8'h00);
        exp_cmd[n_exp + 4] = mk(1'b0, 13'h0FF, 8'h01);
        n_exp = n_exp + 5;
    endtask

    task automatic begin_test(input logic [7:0] f, input logic [7:0] r);
        id_first = f;
        id_rest  = r;
        id_base  = id_reads;
        base     = n_cmd;
        rsp_base = n_rsp;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(!busy && (done || error)) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_cmds(input string tag);
        check({tag, "_ncmd"}, 32'(n_cmd - base), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            check($sformatf("%s_cmd%0d", tag, i), 32'(log_cmd[base + i]), 32'(exp_cmd[i]));
        end
    endtask

    function automatic int min_gap();
        int m;
        m = 1000000;
        for (int i = base; i < n_cmd - 1; i++) begin
            if (log_rise[i + 1] - (log_rsp[i] + 1) < m) m = log_rise[i + 1] - (log_rsp[i] + 1);
        end
        return m;
    endfunction

    initial begin
        int st0;
        int k;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_valid", 32'(u_if.cmd_valid), 32'd0);
        check("rst_rw", 32'(u_if.cmd_rw), 32'd0);
        check("rst_addr", 32'(u_if.cmd_addr), 32'd0);
        check("rst_wdata", 32'(u_if.cmd_wdata), 32'd0);
        check("rst_id", 32'(id_seen), 32'd0);

        // Clean run.
        begin_test(8'h93, 8'h93);
        exp_clean(1);
        pulse_start();
        check("clean_busy", 32'(busy), 32'd1);
        wait_end("clean");
        check_cmds("clean");
        check("clean_done", 32'(done), 32'd1);
        check("clean_error", 32'(error), 32'd0);
        check("clean_busy_end", 32'(busy), 32'd0);
        check("clean_id", 32'(id_seen), 32'h93);
        check("clean_gap_ge16", 32'(min_gap() >= 16), 32'd1);

        // ID never matches: 1 + MAX_RETRY reads then error.
        begin_test(8'h00, 8'h00);
        n_exp = 4;
        for (int i = 0; i < 4; i++) exp_cmd[i] = mk(1'b1, 13'h001, 8'h00);
        pulse_start();
        check("idfail_done_clr", 32'(done), 32'd0);
        wait_end("idfail");
        check_cmds("idfail");
        check("idfail_error", 32'(error), 32'd1);
        check("idfail_done", 32'(done), 32'd0);
        check("idfail_id", 32'(id_seen), 32'h00);
        check("idfail_gap_ge16", 32'(min_gap() >= 16), 32'd1);

        // One mismatch then match.
        begin_test(8'h00, 8'h93);
        exp_clean(2);
        pulse_start();
        check("retry_err_clr", 32'(error), 32'd0);
        wait_end("retry");
        check_cmds("retry");
        check("retry_done", 32'(done), 32'd1);
        check("retry_error", 32'(error), 32'd0);
        check("retry_id", 32'(id_seen), 32'h93);

        // cmd_ready held low 50 cycles on the 014 write.
        st0         = stall_total;
        stall_addr  = 13'h014;
        stall_limit = stall_total + 50;
        begin_test(8'h93, 8'h93);
        exp_clean(1);
        pulse_start();
        wait_end("stall");
        stall_addr = 13'h1FFF;
        check("stall_cycles", 32'(stall_total - st0), 32'd50);
        check("stall_payload_bad", 32'(stall_bad), 32'd0);
        check_cmds("stall");
        check("stall_done", 32'(done), 32'd1);

        // Start while busy and a stray response during the gap.
        begin_test(8'h93, 8'h93);
        exp_clean(1);
        pulse_start();
        k = 0;
        while (n_rsp - rsp_base < 2 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("spur_wait_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        spur_req_n++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("spur_busy", 32'(busy), 32'd1);
        wait_end("spur");
        check_cmds("spur");
        check("spur_done", 32'(done), 32'd1);
        check("spur_id", 32'(id_seen), 32'h93);

        // Reset while the 014 write is pending, then rerun.
        stall_addr  = 13'h014;
        stall_limit = stall_total + 1000;
        begin_test(8'h93, 8'h93);
        pulse_start();
        k = 0;
        while (!(u_if.cmd_valid && u_if.cmd_addr == 13'h014) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("rstmid_wait_timeout", 32'd0, 32'd1);
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(u_if.cmd_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_addr", 32'(u_if.cmd_addr), 32'd0);
        check("rstmid_wdata", 32'(u_if.cmd_wdata), 32'd0);
        check("rstmid_rw", 32'(u_if.cmd_rw), 32'd0);
        check("rstmid_id", 32'(id_seen), 32'd0);
        repeat (3) @(negedge clk);
        reset_n    = 1'b1;
        stall_addr = 13'h1FFF;
        @(negedge clk);
        begin_test(8'h93, 8'h93);
        exp_clean(1);
        pulse_start();
        wait_end("rerun");
        check_cmds("rerun");
        check("rerun_done", 32'(done), 32'd1);
        check("rerun_error", 32'(error), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
